// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter and the LSU.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int unsigned WORD_BYTES = 4;

    // True when a byte address is word aligned and inside a RAM of depth words.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] limit;
        limit = 32'(depth * WORD_BYTES);
        return (addr[1:0] == 2'b00) && (addr < limit);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported data RAM between the
// instruction-fetch port and the load/store port. Each granted access is
// registered, drives the RAM for one cycle, then acks with registered data.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH           = 64,
    parameter bit          D_PRIORITY_INIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_t      state_reg;
    logic        port_reg;
    logic        we_reg;
    logic        err_reg;
    logic        last_grant_reg;

    logic        grant_valid;
    logic        grant_port;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic        sel_err;
    logic [31:0] access_rdata;

    // Decide whether a new request is granted this cycle and to which port.
    // In RESP only the port that is not being acked may be considered.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = PORT_I;
        case (state_reg)
            ST_IDLE: begin
                if (i_req && d_req) begin
                    grant_valid = 1'b1;
                    grant_port  = ~last_grant_reg;
                end else if (d_req) begin
                    grant_valid = 1'b1;
                    grant_port  = PORT_D;
                end else if (i_req) begin
                    grant_valid = 1'b1;
                    grant_port  = PORT_I;
                end
            end
            ST_RESP: begin
                if (port_reg == PORT_I) begin
                    grant_valid = d_req;
                    grant_port  = PORT_D;
                end else begin
                    grant_valid = i_req;
                    grant_port  = PORT_I;
                end
            end
            default: begin
                grant_valid = 1'b0;
                grant_port  = PORT_I;
            end
        endcase
    end

    // Select the winning port's request fields and check its address.
    always_comb begin
        sel_addr  = i_addr;
        sel_wdata = '0;
        sel_we    = 1'b0;
        if (grant_port == PORT_D) begin
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
            sel_we    = d_we;
        end
        sel_err = ~addr_ok(sel_addr, DEPTH);
    end

    // Stores and rejected requests return zero instead of RAM contents.
    assign access_rdata = (we_reg || err_reg) ? '0 : ram_rdata;

    // Arbiter FSM with registered RAM drive and registered responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            port_reg       <= PORT_I;
            we_reg         <= 1'b0;
            err_reg        <= 1'b0;
            last_grant_reg <= ~D_PRIORITY_INIT;
            i_ack          <= 1'b0;
            i_err          <= 1'b0;
            i_rdata        <= '0;
            d_ack          <= 1'b0;
            d_err          <= 1'b0;
            d_rdata        <= '0;
            ram_we         <= 1'b0;
            ram_addr       <= '0;
            ram_wdata      <= '0;
        end else begin
            i_ack  <= 1'b0;
            i_err  <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            ram_we <= 1'b0;
            case (state_reg)
                ST_ACCESS: begin
                    if (port_reg == PORT_D) begin
                        d_ack   <= 1'b1;
                        d_err   <= err_reg;
                        d_rdata <= access_rdata;
                    end else begin
                        i_ack   <= 1'b1;
                        i_err   <= err_reg;
                        i_rdata <= access_rdata;
                    end
                    state_reg <= ST_RESP;
                end
                default: begin
                    // IDLE and RESP both accept a new grant; anything else falls to IDLE.
                    if (grant_valid) begin
                        port_reg       <= grant_port;
                        we_reg         <= sel_we;
                        err_reg        <= sel_err;
                        last_grant_reg <= grant_port;
                        ram_addr       <= sel_addr;
                        ram_wdata      <= sel_wdata;
                        ram_we         <= sel_we & ~sel_err;
                        state_reg      <= ST_ACCESS;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_mem_port_arbiter;

    localparam bit D_PRIO = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_ram = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic        ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic [31:0] ram [64];

    int n_total = 0;
    int n_pass  = 0;

    mem_port_arbiter #(.DEPTH(64), .D_PRIORITY_INIT(D_PRIO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Attached RAM: synchronous write, combinational read.
    always @(posedge clk) begin
        if (init_ram) begin
            for (int k = 0; k < 64; k++) ram[k] <= '0;
            ram[5] <= 32'hDEADBEEF;
        end else if (ram_we) begin
            ram[ram_addr[7:2]] <= ram_wdata;
        end
    end
    assign ram_rdata = ram[ram_addr[7:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- transaction-level model ----------------
    // A transaction is in flight from its grant until its ack is shown.
    bit          t_valid, t_acked, t_port, t_we, t_err;
    logic [31:0] t_addr, t_wdata;
    bit          m_last;
    logic [31:0] m_mem [64];
    bit          offer_i, offer_d, pick_d;
    logic [31:0] m_rd;
    bit          exp_i_ack, exp_i_err, exp_d_ack, exp_d_err, exp_ram_we;
    logic [31:0] exp_i_rdata, exp_d_rdata, exp_ram_addr, exp_ram_wdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t_valid = 0; t_acked = 0; m_last = ~D_PRIO;
            exp_i_ack = 0; exp_i_err = 0; exp_d_ack = 0; exp_d_err = 0; exp_ram_we = 0;
            exp_i_rdata = 0; exp_d_rdata = 0; exp_ram_addr = 0; exp_ram_wdata = 0;
            if (init_ram) begin
                for (int k = 0; k < 64; k++) m_mem[k] = '0;
                m_mem[5] = 32'hDEADBEEF;
            end
        end else begin
            exp_i_ack = 0; exp_i_err = 0; exp_d_ack = 0; exp_d_err = 0; exp_ram_we = 0;
            if (t_valid && !t_acked) begin
                // The memory operation completes; its response shows next cycle.
                m_rd = '0;
                if (!t_err) begin
                    if (t_we) m_mem[t_addr[7:2]] = t_wdata;
                    else      m_rd = m_mem[t_addr[7:2]];
                end
                if (t_port) begin exp_d_ack = 1; exp_d_err = t_err; exp_d_rdata = m_rd; end
                else        begin exp_i_ack = 1; exp_i_err = t_err; exp_i_rdata = m_rd; end
                t_acked = 1;
            end else begin
                // A port whose ack is showing cannot be granted again yet.
                offer_i = i_req && !(t_valid && !t_port);
                offer_d = d_req && !(t_valid && t_port);
                t_valid = 0;
                if (offer_i || offer_d) begin
                    pick_d  = offer_d && (!offer_i || !m_last);
                    t_valid = 1; t_acked = 0; t_port = pick_d; m_last = pick_d;
                    t_addr  = pick_d ? d_addr : i_addr;
                    t_we    = pick_d ? d_we : 1'b0;
                    t_wdata = pick_d ? d_wdata : 32'h0;
                    t_err   = (t_addr % 4 != 0) || (t_addr >= 256);
                    exp_ram_we    = t_we && !t_err;
                    exp_ram_addr  = t_addr;
                    exp_ram_wdata = t_wdata;
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            chk("i_ack",   32'(i_ack),  32'(exp_i_ack));
            chk("i_err",   32'(i_err),  32'(exp_i_err));
            chk("i_rdata", i_rdata,     exp_i_rdata);
            chk("d_ack",   32'(d_ack),  32'(exp_d_ack));
            chk("d_err",   32'(d_err),  32'(exp_d_err));
            chk("d_rdata", d_rdata,     exp_d_rdata);
            chk("ram_we",  32'(ram_we), 32'(exp_ram_we));
            if (t_valid && !t_acked) chk("ram_addr", ram_addr, exp_ram_addr);
            if (exp_ram_we)          chk("ram_wdata", ram_wdata, exp_ram_wdata);
        end
    end

    // One request on one port, held until ack (bounded); reports latency and ram_we pulses.
    task automatic port_access(input bit is_d, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rd,
                               output bit er, output int lat, output int wes);
        bit got;
        got = 0; lat = 0; wes = 0; rd = 'x; er = 0;
        @(negedge clk);
        if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
        else      begin i_req = 1; i_addr = addr; end
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (ram_we) wes++;
            if (is_d && d_ack)  begin got = 1; rd = d_rdata; er = d_err; end
            if (!is_d && i_ack) begin got = 1; rd = i_rdata; er = i_err; end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        d_req = 0; i_req = 0;
        $display("txn port=%s we=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d we_pulses=%0d",
                 is_d ? "D" : "I", we, addr, wdata, rd, er, lat, wes);
    endtask

    initial begin
        logic [31:0] rd;
        bit          er;
        int          lat, wes;
        logic [7:0]  dmask, imask;
        logic [31:0] saved;

        // Contention: both ports requesting straight out of reset.
        i_req = 1; i_addr = 32'h14; d_req = 1; d_we = 0; d_addr = 32'h0C;
        repeat (3) @(negedge clk);
        init_ram = 0;
        @(negedge clk);
        reset = 0;
        dmask = 0; imask = 0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (d_ack) dmask[c] = 1'b1;
            if (i_ack) imask[c] = 1'b1;
            if (c == 4) chk("contend_i_rdata", i_rdata, 32'hDEADBEEF);
            if (c == 6) begin i_req = 0; d_req = 0; end
        end
        $display("contention d_ack cycles mask=%08b i_ack cycles mask=%08b", dmask, imask);
        chk("contend_d_cycles", 32'(dmask), 32'h44);
        chk("contend_i_cycles", 32'(imask), 32'h10);

        // Single load of preloaded word 5.
        port_access(1, 0, 32'h14, 32'h0, rd, er, lat, wes);
        chk("load_rdata", rd, 32'hDEADBEEF);
        chk("load_model_rdata", exp_d_rdata, 32'hDEADBEEF);
        chk("load_err", 32'(er), 32'd0);
        chk("load_latency", 32'(lat), 32'd2);
        chk("load_we_pulses", 32'(wes), 32'd0);

        // Store then fetch the same word.
        port_access(1, 1, 32'h08, 32'h12345678, rd, er, lat, wes);
        chk("store_rdata", rd, 32'h0);
        chk("store_latency", 32'(lat), 32'd2);
        chk("store_we_pulses", 32'(wes), 32'd1);
        chk("store_ram_word", ram[2], 32'h12345678);
        port_access(0, 0, 32'h08, 32'h0, rd, er, lat, wes);
        chk("fetch_rdata", rd, 32'h12345678);
        chk("fetch_err", 32'(er), 32'd0);
        chk("fetch_latency", 32'(lat), 32'd2);
        chk("d_rdata_held", d_rdata, 32'h0);

        // Misaligned store and out-of-range fetch.
        saved = ram[0];
        port_access(1, 1, 32'h102, 32'hFFFFFFFF, rd, er, lat, wes);
        chk("err_store_err", 32'(er), 32'd1);
        chk("err_store_rdata", rd, 32'h0);
        chk("err_store_we_pulses", 32'(wes), 32'd0);
        chk("err_store_ram_unchanged", ram[0], saved);
        port_access(0, 0, 32'h100, 32'h0, rd, er, lat, wes);
        chk("err_fetch_err", 32'(er), 32'd1);
        chk("err_fetch_rdata", rd, 32'h0);
        port_access(0, 0, 32'hFC, 32'h0, rd, er, lat, wes);
        chk("last_word_err", 32'(er), 32'd0);
        chk("last_word_rdata", rd, 32'h0);

        // Reset during the ACCESS cycle of a store.
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        chk("rst_access_we_before", 32'(ram_we), 32'd1);
        reset = 1;
        #1;
        chk("rst_we_async", 32'(ram_we), 32'd0);
        chk("rst_no_ack", 32'(d_ack), 32'd0);
        d_req = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_no_ack", 32'(d_ack | i_ack), 32'd0);
        end
        reset = 0;
        chk("rst_store_lost", ram[8], 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        $display("reset mid-access: ram_we=%0d d_ack=%0d ram[8]=0x%08h", ram_we, d_ack, ram[8]);

        // Fresh request after reset.
        port_access(1, 0, 32'h08, 32'h0, rd, er, lat, wes);
        chk("post_rst_rdata", rd, 32'h12345678);
        chk("post_rst_latency", 32'(lat), 32'd2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
